// File: rtl/flopenr_pipe.sv
// flopenr_pipe: DEPTH-stage enabled register chain with per-stage valid bits,
// bubble collapse, back-pressure and synchronous flush. Define PIPE_OCC_EN for the occ counter.
module flopenr_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef PIPE_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

   // Handshake: a word moves across a boundary on a cycle where valid & ready are both 1;
   // valid never waits on ready, and a producer holds data steady while valid & !ready.
   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] d     [DEPTH];
   logic [WIDTH-1:0] src_d [DEPTH];
   logic             acc;

   // A stage is ready when it or any stage downstream of it has room, or the sink drains.
   always_comb begin
      rdy = '0;
      acc = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         acc    = acc | ~v[i];
         rdy[i] = acc;
      end
   end

   always_comb begin
      src_v[0] = in_valid;
      src_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_v[i] = v[i-1];
         src_d[i] = d[i-1];
      end
   end

   assign in_ready  = rdy[0] & ~flush;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v <= '0;
      end else if (flush) begin
         v <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) v[i] <= src_v[i];
         end
      end
   end

   // Data only loads on a valid transfer so bubbles leave the retained word untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) d[i] <= RESET_VAL;
      end else if (!flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && src_v[i]) d[i] <= src_d[i];
         end
      end
   end

`ifdef PIPE_OCC_EN
   localparam int OW = $clog2(DEPTH + 1);
   logic in_x;
   logic out_x;

   assign in_x  = in_valid & in_ready;
   assign out_x = out_valid & out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ <= '0;
      end else if (flush) begin
         occ <= '0;
      end else if (in_x && !out_x) begin
         occ <= occ + OW'(1);
      end else if (!in_x && out_x) begin
         occ <= occ - OW'(1);
      end
   end
`endif

endmodule
